// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundles the pipeline-side hazard inputs and the stall/flush/status outputs
// of hazard_ctrl.
//   master : pipeline side (drives ID/EX/MEM hazard info, receives controls)
//   slave  : hazard_ctrl (receives hazard info, drives controls and counters)
// Parameter CNT_W sets the performance-counter width and must match the
// hazard_ctrl instance it connects to.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_rs1_used;
    logic             ID_rs2_used;
    logic             ID_jump;
    logic [4:0]       EX_rd;
    logic             EX_mem_read;
    logic             EX_branch_taken;
    logic             MEM_req;
    logic             MEM_ready;

    logic             stall_IF;
    logic             stall_ID;
    logic             flush_ID;
    logic             flush_EX;
    logic             stall_EX;
    logic             flush_WB;
    logic             mem_busy;
    logic             err;
    logic [CNT_W-1:0] cnt_lu;
    logic [CNT_W-1:0] cnt_flush;
    logic [CNT_W-1:0] cnt_mem;

    modport master (
        output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_jump,
               EX_rd, EX_mem_read, EX_branch_taken, MEM_req, MEM_ready,
        input  stall_IF, stall_ID, flush_ID, flush_EX, stall_EX, flush_WB,
               mem_busy, err, cnt_lu, cnt_flush, cnt_mem
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_jump,
               EX_rd, EX_mem_read, EX_branch_taken, MEM_req, MEM_ready,
        output stall_IF, stall_ID, flush_ID, flush_EX, stall_EX, flush_WB,
               mem_busy, err, cnt_lu, cnt_flush, cnt_mem
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall/flush controller for the five-stage pipeline. Detects load-use
// hazards, branch/jump redirects and data-memory wait states and drives the
// hold/bubble controls of the PC and pipeline registers. A small FSM tracks
// memory waits and latches a sticky error on timeout.
//
// Ports:
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   hz    : hazard_ctrl_if.slave (hazard inputs, stall/flush outputs,
//           mem_busy, err, performance counters)
//
// Parameters:
//   MEM_TIMEOUT : consecutive MEM_WAIT stall cycles tolerated before ERR
//                 (1..65535)
//   CNT_W       : performance-counter width
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> cnt_lu / cnt_flush / cnt_mem count winning conditions,
//                wrap at 2^CNT_W and freeze in ERR
//   undefined -> no counter registers, cnt_* tied to 0
//
// State | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow, no memory access outstanding beyond this cycle
// MEM_WAIT | at least one memory-stall cycle seen; wait_cnt counts them
// ERR   | memory timed out; pipeline frozen until reset
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic lu;
    logic ms;
    logic c_mem, c_br, c_lu, c_jmp;

    always_comb begin
        lu = hz.EX_mem_read && (hz.EX_rd != 5'd0) &&
             ((hz.ID_rs1_used && (hz.ID_rs1 == hz.EX_rd)) ||
              (hz.ID_rs2_used && (hz.ID_rs2 == hz.EX_rd)));
        ms = hz.MEM_req && !hz.MEM_ready;
    end

    // One-hot winner of the priority chain. In ERR the memory condition wins
    // regardless of MEM_ready. A branch under a memory stall is simply not
    // acted on: EX is frozen, so it re-presents after the stall releases.
    always_comb begin
        c_mem = (state_q == ERR) || ms;
        c_br  = !c_mem && hz.EX_branch_taken;
        c_lu  = !c_mem && !hz.EX_branch_taken && lu;
        c_jmp = !c_mem && !hz.EX_branch_taken && !lu && hz.ID_jump;
    end

    // Controls are Mealy so the pipeline registers act on the same edge;
    // gating with rst_n keeps them quiet while reset is held.
    always_comb begin
        hz.stall_IF = rst_n && (c_mem || c_lu);
        hz.stall_ID = rst_n && (c_mem || c_lu);
        hz.flush_ID = rst_n && (c_br || c_jmp);
        hz.flush_EX = rst_n && (c_br || c_lu);
        hz.stall_EX = rst_n && c_mem;
        hz.flush_WB = rst_n && c_mem;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (ms) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!ms) begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q == TIMEOUT) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign hz.mem_busy = (state_q == MEM_WAIT);
    assign hz.err      = (state_q == ERR);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
    logic [CNT_W-1:0] cnt_mem_q, cnt_mem_d;

    always_comb begin
        cnt_lu_d    = cnt_lu_q;
        cnt_flush_d = cnt_flush_q;
        cnt_mem_d   = cnt_mem_q;
        if (state_q != ERR) begin
            if (c_lu)
                cnt_lu_d = cnt_lu_q + 1'b1;
            if (c_br || c_jmp)
                cnt_flush_d = cnt_flush_q + 1'b1;
            if (c_mem)
                cnt_mem_d = cnt_mem_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lu_q    <= '0;
            cnt_flush_q <= '0;
            cnt_mem_q   <= '0;
        end else begin
            cnt_lu_q    <= cnt_lu_d;
            cnt_flush_q <= cnt_flush_d;
            cnt_mem_q   <= cnt_mem_d;
        end
    end

    assign hz.cnt_lu    = cnt_lu_q;
    assign hz.cnt_flush = cnt_flush_q;
    assign hz.cnt_mem   = cnt_mem_q;
`else
    assign hz.cnt_lu    = '0;
    assign hz.cnt_flush = '0;
    assign hz.cnt_mem   = '0;
`endif

endmodule
